// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Holds the state encoding, opcode/funct constants, the 4-bit ALU operation
// codes, the ALUSrcB/PCSource mux codes and the packed control bundle that the
// top level drives onto its individual output ports.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExR,
        StExI,
        StExAddr,
        StMemRd,
        StMemWr,
        StWbR,
        StWbMem,
        StBr,
        StJmp
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnAddu = 6'b100001;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnSubu = 6'b100011;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnJr   = 6'b001000;

    // ALU operation codes
    localparam logic [3:0] AluNone = 4'b0000;
    localparam logic [3:0] AluAdd  = 4'b0001;
    localparam logic [3:0] AluSub  = 4'b0010;
    localparam logic [3:0] AluAnd  = 4'b0011;
    localparam logic [3:0] AluOr   = 4'b0100;
    localparam logic [3:0] AluNor  = 4'b0101;
    localparam logic [3:0] AluSlt  = 4'b0110;
    localparam logic [3:0] AluSll  = 4'b0111;
    localparam logic [3:0] AluSrl  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1001;
    localparam logic [3:0] AluAddu = 4'b1010;
    localparam logic [3:0] AluSubu = 4'b1011;

    // ALUSrcB mux select
    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // PCSource mux select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcRs     = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_alu_decode.sv
// R-type funct decoder.
// Maps an R-type funct field onto the 4-bit ALU operation code and flags
// whether the funct is one this datapath supports.
//   funct  in  6  R-type funct field
//   alu_op out 4  ALU operation code (AluNone when not supported)
//   valid  out 1  funct is a supported ALU operation
module mc_control_fsm_alu_decode
    import mc_control_fsm_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = AluNone;
        valid  = 1'b1;
        case (funct)
            FnAdd:   alu_op = AluAdd;
            FnAddu:  alu_op = AluAddu;
            FnSub:   alu_op = AluSub;
            FnSubu:  alu_op = AluSubu;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            FnNor:   alu_op = AluNor;
            FnSlt:   alu_op = AluSlt;
            FnSll:   alu_op = AluSll;
            FnSrl:   alu_op = AluSrl;
            FnSra:   alu_op = AluSra;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer.
// Steps one instruction through FETCH/DECODE/execute/memory/write-back states
// on a shared ALU/memory datapath, waiting on a memory ready handshake with a
// timeout, and supports a freeze (stall) input.
//   clk, rst           clock, synchronous active-high reset
//   opcode, funct      instruction fields, sampled in DECODE
//   zero               ALU zero flag (gated with PCWriteCond in the datapath)
//   mem_ready          memory completes the current access this cycle
//   stall              freeze state, force write/read enables low
//   PCWrite..PCSource  datapath enables and mux selects
//   ALUOp              4-bit ALU operation
//   instr_done         pulse on the last cycle of an instruction
//   illegal            pulse when an unsupported instruction is decoded
//   mem_err            pulse on memory-wait timeout
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int unsigned TO_W   = 8,
    parameter int unsigned TO_MAX = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       stall,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [5:0]      op_q, funct_q;
    ctrl_t           ctl;

    logic [5:0] dec_funct;
    logic [3:0] dec_alu_op;
    logic       dec_valid;
    logic       mem_wait;

    // The branch condition is resolved in the datapath from zero & PCWriteCond.
    logic unused_zero;
    assign unused_zero = zero;

    // One decoder serves both the legality check in DECODE and EX_R's ALUOp.
    assign dec_funct = (state_q == StDecode) ? funct : funct_q;

    mc_control_fsm_alu_decode u_alu_decode (
        .funct  (dec_funct),
        .alu_op (dec_alu_op),
        .valid  (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StDecode && !stall) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        ctl      = '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_wait = 1'b0;

        case (state_q)
            StFetch: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SrcBFour;
                ctl.alu_op    = AluAdd;
                ctl.pc_source = PcSrcAlu;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = StDecode;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            StDecode: begin
                ctl.alu_src_b = SrcBImmSh;
                ctl.alu_op    = AluAdd;
                case (opcode)
                    OpRtype: begin
                        if (funct == FnJr)   state_d = StJmp;
                        else if (dec_valid)  state_d = StExR;
                        else                 state_d = StFetch;
                    end
                    OpLw, OpSw: state_d = StExAddr;
                    OpAddi:     state_d = StExI;
                    OpBeq:      state_d = StBr;
                    OpJ:        state_d = StJmp;
                    default:    state_d = StFetch;
                endcase
                if (state_d == StFetch) begin
                    ctl.illegal    = 1'b1;
                    ctl.instr_done = 1'b1;
                end
            end
            StExR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SrcBReg;
                ctl.alu_op    = dec_alu_op;
                state_d       = StWbR;
            end
            StExI: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SrcBImm;
                ctl.alu_op    = AluAdd;
                state_d       = StWbR;
            end
            StExAddr: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SrcBImm;
                ctl.alu_op    = AluAdd;
                state_d       = (op_q == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (mem_ready) state_d = StWbMem;
                else           mem_wait = 1'b1;
            end
            StMemWr: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    ctl.instr_done = 1'b1;
                    state_d        = StFetch;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            StWbR: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = (op_q == OpRtype);
                ctl.instr_done = 1'b1;
                state_d        = StFetch;
            end
            StWbMem: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = StFetch;
            end
            StBr: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SrcBReg;
                ctl.alu_op        = AluSub;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PcSrcAluOut;
                ctl.instr_done    = 1'b1;
                state_d           = StFetch;
            end
            StJmp: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = (op_q == OpJ) ? PcSrcJump : PcSrcRs;
                ctl.instr_done = 1'b1;
                state_d        = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Timeout abandons the access: only the error/done pulses remain.
        if (mem_wait) begin
            if (cnt_q == TO_W'(TO_MAX)) begin
                ctl            = '0;
                ctl.mem_err    = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = StFetch;
                cnt_d          = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (state_d != state_q) cnt_d = '0;

        // Stall freezes everything; mux selects stay valid for the datapath.
        if (stall) begin
            state_d           = state_q;
            cnt_d             = cnt_q;
            ctl.pc_write      = 1'b0;
            ctl.pc_write_cond = 1'b0;
            ctl.ir_write      = 1'b0;
            ctl.reg_write     = 1'b0;
            ctl.mem_write     = 1'b0;
            ctl.mem_read      = 1'b0;
            ctl.instr_done    = 1'b0;
            ctl.illegal       = 1'b0;
            ctl.mem_err       = 1'b0;
        end

        if (rst) ctl = '0;
    end

    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign IorD        = ctl.i_or_d;
    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign IRWrite     = ctl.ir_write;
    assign RegWrite    = ctl.reg_write;
    assign RegDst      = ctl.reg_dst;
    assign MemToReg    = ctl.mem_to_reg;
    assign ALUSrcA     = ctl.alu_src_a;
    assign ALUSrcB     = ctl.alu_src_b;
    assign PCSource    = ctl.pc_source;
    assign ALUOp       = ctl.alu_op;
    assign instr_done  = ctl.instr_done;
    assign illegal     = ctl.illegal;
    assign mem_err     = ctl.mem_err;

endmodule
